ram_ctrl: RTL
=============

// Module: ram_ctrl
// PURPOSE
//   Scrambling controller between the CPU bus and the single-port main RAM. It consumes the
//   ram_aslr and ram_scramble keys that the tk1 core produces. Word addresses are XORed with
//   the ASLR key. Data is XORed with the scramble key and the logical address.
//   After reset it sweeps the whole RAM with zeros before it serves any CPU access.
// PARAMETERS
//   ADDR_WIDTH      15   word-address width; RAM depth = 2**ADDR_WIDTH words
//   CLEAR_ON_RESET  1    1: run the zero sweep after reset; 0: enter IDLE directly
// PORTS
//   clk           in   1           system clock
//   reset         in   1           synchronous, active-high reset
//   ram_aslr      in   ADDR_WIDTH  address XOR key from tk1
//   ram_scramble  in   32          data XOR key from tk1
//   cs            in   1           CPU request; held high until ready
//   we            in   4           byte write enables; 4'h0 = read
//   address       in   ADDR_WIDTH  logical word address
//   write_data    in   32          CPU write data
//   read_data     out  32          descrambled read data, valid while ready=1
//   ready         out  1           one-cycle completion pulse
//   clear_done    out  1           1 once the zero sweep has finished
//   mem_cs        out  1           RAM enable
//   mem_wmask     out  4           RAM byte write mask; 4'h0 = read
//   mem_addr      out  ADDR_WIDTH  physical word address
//   mem_wdata     out  32          scrambled write data
//   mem_rdata     in   32          RAM read data, valid 1 cycle after a read-enable cycle
// BEHAVIOUR
//   - Reset values: read_data=0, ready=0, clear_done=0, mem_cs=0, mem_wmask=0, mem_addr=0,
//     mem_wdata=0. State=CLEAR (or IDLE with clear_done=1 if CLEAR_ON_RESET=0). Sweep counter=0.
//   - CLEAR: each cycle drives mem_cs=1, mem_wmask=4'hF, mem_addr=ctr, mem_wdata=0 (raw zeros, no
//     key applied), then ctr++. At ctr==2**ADDR_WIDTH-1 that write is the last one; next state is
//     IDLE and clear_done=1. The sweep takes exactly 2**ADDR_WIDTH cycles.
//   - CLEAR with cs=1: the request is stalled with ready=0 and is served from IDLE afterwards.
//   - IDLE with cs=1: latch the keys and address (kA=ram_aslr, kS=ram_scramble, la=address).
//     mem_cs=1, mem_addr=address^ram_aslr (same-cycle combinational drive).
//   - Write (we!=0): mem_wmask=we and mem_wdata=write_data^ram_scramble^{zero-ext la}.
//     Next state is ACK, so ready is high in cycle +1.
//   - Read (we==0): mem_wmask=0, next state is RD_WAIT. In RD_WAIT, read_data <=
//     mem_rdata^kS^{zero-ext la}, next state is ACK. ready is high in cycle +2.
//   - ACK: ready=1 for exactly one cycle, then IDLE. cs still high during ACK is not a new
//     request. The earliest new accept is the IDLE cycle after ACK.
//   - Keys are used only as latched at accept. A ram_aslr or ram_scramble change mid-transaction
//     does not affect the transaction in flight.
//   - Address XOR wraps within ADDR_WIDTH bits, so no out-of-range physical address exists.
//   - mem_cs=0 in RD_WAIT and ACK. mem_cs=0 in IDLE when cs=0.
//   - Reset mid-operation: the transaction is abandoned with no ready pulse, clear_done drops to
//     0, and the sweep restarts at word 0.
//   - Scramble key width: the address term is {32-ADDR_WIDTH zero bits, la}.
//     XOR is bytewise, so partial byte writes descramble correctly.
// TESTING  (bench uses ADDR_WIDTH=4)
//   - reset 1 cycle -> 16 cycles of mem_wmask=F, mem_wdata=0, mem_addr 0..F; clear_done=1 in cycle 17.
//   - aslr=3, scramble=A5A5A5A5, write addr=1, data=12345678, we=F -> mem_addr=2,
//     mem_wdata=B791F3DC, ready in cycle +1.
//   - Read addr=1 with the same keys -> mem_addr=2, ready in cycle +2, read_data=12345678.
//   - Same location read with scramble changed to 0 -> read_data=B791F3DD.
//     A key change during RD_WAIT has no effect on the result.
//   - we=4'b0010 write -> mem_wmask=0010, other bytes are unchanged on readback.
//   - cs held during CLEAR -> ready=0 until clear_done. Reset asserted in RD_WAIT -> no ready,
//     and the sweep restarts at mem_addr=0.

Source files
------------

// File: rtl/ram_ctrl.sv
// Scrambling controller between the CPU bus and single-port main RAM: XORs word addresses with the
// ASLR key and data with the scramble key plus logical address, after an optional zero sweep.
module ram_ctrl #(
  parameter int unsigned ADDR_WIDTH     = 15,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] ram_aslr,
  input  logic [31:0]           ram_scramble,
  input  logic                  cs,
  input  logic [3:0]            we,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [31:0]           write_data,
  output logic [31:0]           read_data,
  output logic                  ready,
  output logic                  clear_done,
  output logic                  mem_cs,
  output logic [3:0]            mem_wmask,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);

  localparam int unsigned PadWidth = 32 - ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] CtrLast = '1;

  typedef enum logic [1:0] {StClear, StIdle, StRdWait, StAck} state_e;

  localparam state_e StReset = CLEAR_ON_RESET ? StClear : StIdle;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ctr_q, ctr_d;
  logic [ADDR_WIDTH-1:0] la_q, la_d;
  logic [31:0]           ks_q, ks_d;
  logic [31:0]           read_data_q, read_data_d;
  logic                  clear_done_q, clear_done_d;

  function automatic logic [31:0] addr_term(input logic [ADDR_WIDTH-1:0] a);
    return {{PadWidth{1'b0}}, a};
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StReset;
      ctr_q        <= '0;
      la_q         <= '0;
      ks_q         <= '0;
      read_data_q  <= '0;
      clear_done_q <= !CLEAR_ON_RESET;
    end else begin
      state_q      <= state_d;
      ctr_q        <= ctr_d;
      la_q         <= la_d;
      ks_q         <= ks_d;
      read_data_q  <= read_data_d;
      clear_done_q <= clear_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    ctr_d        = ctr_q;
    la_d         = la_q;
    ks_d         = ks_q;
    read_data_d  = read_data_q;
    clear_done_d = clear_done_q;
    unique case (state_q)
      StClear: begin
        ctr_d = ctr_q + ADDR_WIDTH'(1);
        if (ctr_q == CtrLast) begin
          state_d      = StIdle;
          clear_done_d = 1'b1;
        end
      end
      StIdle: begin
        if (cs) begin
          // Only the scramble key and logical address are needed after the accept cycle.
          la_d    = address;
          ks_d    = ram_scramble;
          state_d = (we == 4'h0) ? StRdWait : StAck;
        end
      end
      StRdWait: begin
        read_data_d = mem_rdata ^ ks_q ^ addr_term(la_q);
        state_d     = StAck;
      end
      StAck: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    read_data  = read_data_q;
    clear_done = clear_done_q;
    ready      = 1'b0;
    mem_cs     = 1'b0;
    mem_wmask  = 4'h0;
    mem_addr   = '0;
    mem_wdata  = '0;
    // Keep the RAM quiet while reset is held, whatever state the register still shows.
    if (!reset) begin
      unique case (state_q)
        StClear: begin
          mem_cs    = 1'b1;
          mem_wmask = 4'hF;
          mem_addr  = ctr_q;
        end
        StIdle: begin
          if (cs) begin
            mem_cs    = 1'b1;
            mem_wmask = we;
            mem_addr  = address ^ ram_aslr;
            if (we != 4'h0) begin
              mem_wdata = write_data ^ ram_scramble ^ addr_term(address);
            end
          end
        end
        StAck: begin
          ready = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
